// File: rtl/game_timer_pkg.sv
// game_timer_pkg
// Shared types and helpers for the BCD game timer.
//   bcd_digit_t : one packed BCD digit
//   BCD_ZERO / BCD_NINE : digit limits
//   mode_e      : count direction (MODE_DOWN = 0, MODE_UP = 1)
//   bcd_clamp() : forces an out-of-range nibble (A..F) to 9
package game_timer_pkg;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_ZERO = 4'd0;
   localparam bcd_digit_t BCD_NINE = 4'd9;

   typedef enum logic {
      MODE_DOWN = 1'b0,
      MODE_UP   = 1'b1
   } mode_e;

   function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
      return (d > BCD_NINE) ? BCD_NINE : d;
   endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell
// One BCD digit of the timer datapath. Purely combinational; the top chains
// DIGITS copies through c_i/c_o.
//   dir_i  : MODE_UP   -> q_o = d_i + a_i + c_i, c_o = decimal carry
//            MODE_DOWN -> q_o = d_i - c_i,       c_o = decimal borrow
//   d_i    : current digit (assumed valid BCD)
//   a_i    : addend digit (0 for a plain increment, bonus digit otherwise)
//   c_i    : carry-in (up) or borrow-in (down)
//   q_o    : resulting digit
//   c_o    : carry-out / borrow-out
//   flag_o : terminal-value flag for the direction: is-nine (up), is-zero (down)
module bcd_digit_cell
   import game_timer_pkg::*;
(
   input  mode_e      dir_i,
   input  bcd_digit_t d_i,
   input  bcd_digit_t a_i,
   input  logic       c_i,
   output bcd_digit_t q_o,
   output logic       c_o,
   output logic       flag_o
);

   // Widest case is 9 + 9 + 1 = 19, so five bits suffice.
   logic [4:0] sum;

   always_comb begin
      sum = {1'b0, d_i} + {1'b0, a_i} + {4'b0000, c_i};
      q_o = d_i;
      c_o = 1'b0;
      if (dir_i == MODE_UP) begin
         if (sum > 5'd9) begin
            q_o = 4'(sum - 5'd10);
            c_o = 1'b1;
         end else begin
            q_o = sum[3:0];
         end
      end else begin
         // Borrow into a zero digit wraps it to nine and propagates.
         if (c_i && (d_i == BCD_ZERO)) begin
            q_o = BCD_NINE;
            c_o = 1'b1;
         end else begin
            q_o = d_i - {3'b000, c_i};
         end
      end
   end

   assign flag_o = (dir_i == MODE_UP) ? (d_i == BCD_NINE) : (d_i == BCD_ZERO);

endmodule

// File: rtl/bcd_game_timer.sv
// bcd_game_timer
// N-digit BCD game clock / stopwatch driven by a one-cycle 1 Hz tick strobe.
// Optional feature macro: TIMER_BONUS_EN (adds bonus_valid/bonus_val, the
// bonus adder and the deferred-tick register path).
// Parameters:
//   DIGITS      : number of BCD digits (1..6)
//   START_VAL   : BCD value loaded at reset
//   WARN_THRESH : countdown warning threshold (BCD)
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   tick         : one-cycle count strobe
//   pause        : 1 = discard ticks (a pending tick is held)
//   mode         : 0 = count down, 1 = count up
//   load/load_val: one-cycle reload, digits above 9 clamped to 9
//   bonus_valid/bonus_val : one-cycle time bonus, countdown only
//   digits       : current count, digit 0 in bits [3:0]
//   end_game     : sticky expiry flag
//   expire_pulse : high for the first cycle end_game reads 1
//   warn         : countdown at or below WARN_THRESH and not ended
// Per-cycle priority: rst > load > bonus > tick.
module bcd_game_timer
   import game_timer_pkg::*;
#(
   parameter int          DIGITS      = 2,
   parameter int unsigned START_VAL   = 'h60,
   parameter int unsigned WARN_THRESH = 'h10
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  tick,
   input  logic                  pause,
   input  logic                  mode,
   input  logic                  load,
   input  logic [4*DIGITS-1:0]   load_val,
`ifdef TIMER_BONUS_EN
   input  logic                  bonus_valid,
   input  logic [4*DIGITS-1:0]   bonus_val,
`endif
   output logic [4*DIGITS-1:0]   digits,
   output logic                  end_game,
   output logic                  expire_pulse,
   output logic                  warn
);

   localparam int W = 4 * DIGITS;
   localparam logic [W-1:0] START_BCD = START_VAL[W-1:0];
   localparam logic [W-1:0] WARN_BCD  = WARN_THRESH[W-1:0];
   localparam logic [W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

   function automatic logic [W-1:0] clamp_all(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = bcd_clamp(v[4*i +: 4]);
      end
      return r;
   endfunction

   logic [W-1:0] digits_q, digits_d;
   logic         end_game_q, end_game_d;
   logic         expire_q, expire_d;
   logic         tick_pending_q, tick_pending_d;

   mode_e        mode_cur;
   logic         bonus_take;
   logic [W-1:0] add_opnd;

   assign mode_cur = mode_e'(mode);

`ifdef TIMER_BONUS_EN
   assign bonus_take = bonus_valid && (mode_cur == MODE_DOWN) && !end_game_q;
   assign add_opnd   = bonus_take ? clamp_all(bonus_val) : '0;
`else
   // Without the bonus path nothing can set tick_pending, so it stays 0.
   assign bonus_take = 1'b0;
   assign add_opnd   = '0;
`endif

   // ---------------------------------------------------------------------
   // Digit chain. One chain serves tick inc/dec and the bonus add: a bonus
   // forces the add direction with carry-in 0, otherwise the chain steps by
   // one in the current mode (carry/borrow-in 1 at digit 0).
   // ---------------------------------------------------------------------
   mode_e          chain_dir;
   logic [DIGITS:0] chain_c;
   logic [W-1:0]   chain_q;
   logic [DIGITS-1:0] term_flag;

   assign chain_dir  = bonus_take ? MODE_UP : mode_cur;
   assign chain_c[0] = ~bonus_take;

   for (genvar g = 0; g < DIGITS; g++) begin : g_cell
      bcd_digit_cell u_cell (
         .dir_i  (chain_dir),
         .d_i    (digits_q[4*g +: 4]),
         .a_i    (add_opnd[4*g +: 4]),
         .c_i    (chain_c[g]),
         .q_o    (chain_q[4*g +: 4]),
         .c_o    (chain_c[g+1]),
         .flag_o (term_flag[g])
      );
   end

   // All zeros (down) or all nines (up): the next tick ends the game.
   logic at_terminal;
   assign at_terminal = &term_flag;

   logic tick_eff;
   // A held deferred tick behaves like a fresh strobe; both are discarded
   // while paused, but the pending one survives the pause.
   assign tick_eff = (tick || tick_pending_q) && !pause;

   always_comb begin
      digits_d       = digits_q;
      end_game_d     = end_game_q;
      tick_pending_d = tick_pending_q;
      if (load) begin
         digits_d       = clamp_all(load_val);
         end_game_d     = 1'b0;
         tick_pending_d = 1'b0;
      end else if (bonus_take) begin
         // Carry out of the top digit means the sum overflowed: saturate.
         digits_d = chain_c[DIGITS] ? ALL_NINES : chain_q;
         if (tick && !pause) begin
            tick_pending_d = 1'b1;
         end
      end else if (tick_eff) begin
         tick_pending_d = 1'b0;
         if (!end_game_q) begin
            if (at_terminal) begin
               end_game_d = 1'b1;
            end else begin
               digits_d = chain_q;
            end
         end
      end
      expire_d = end_game_d && !end_game_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         digits_q       <= START_BCD;
         end_game_q     <= 1'b0;
         expire_q       <= 1'b0;
         tick_pending_q <= 1'b0;
      end else begin
         digits_q       <= digits_d;
         end_game_q     <= end_game_d;
         expire_q       <= expire_d;
         tick_pending_q <= tick_pending_d;
      end
   end

   assign digits       = digits_q;
   assign end_game     = end_game_q;
   assign expire_pulse = expire_q;
   assign warn         = (mode_cur == MODE_DOWN) && !end_game_q && (digits_q <= WARN_BCD);

endmodule

// File: tb/tb_bcd_game_timer.sv
// tb_bcd_game_timer
// Bench for bcd_game_timer with default parameters (2 digits, start 60,
// warning at 10). A seconds-as-integer reference model tracks the timer;
// every cycle digits, end_game, expire_pulse and warn are compared.
// Bonus stimulus is exercised when TIMER_BONUS_EN is defined.
module tb_bcd_game_timer;

   localparam int DIGITS = 2;
   localparam int W      = 4 * DIGITS;
   localparam int MAXV   = 10 ** DIGITS - 1;
   localparam int START  = 60;
   localparam int WARN_S = 10;
`ifdef TIMER_BONUS_EN
   localparam bit BONUS_EN = 1'b1;
`else
   localparam bit BONUS_EN = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst = 1'b1;
   logic         tick = 1'b0;
   logic         pause = 1'b0;
   logic         mode = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_val = '0;
   logic         bonus_valid = 1'b0;
   logic [W-1:0] bonus_val = '0;
   logic [W-1:0] digits;
   logic         end_game;
   logic         expire_pulse;
   logic         warn;

   bcd_game_timer dut (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .pause        (pause),
      .mode         (mode),
      .load         (load),
      .load_val     (load_val),
`ifdef TIMER_BONUS_EN
      .bonus_valid  (bonus_valid),
      .bonus_val    (bonus_val),
`endif
      .digits       (digits),
      .end_game     (end_game),
      .expire_pulse (expire_pulse),
      .warn         (warn)
   );

   // ---------------- scoreboard ----------------
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model (integer seconds) ----------------
   int m_cnt  = 0;
   bit m_end  = 1'b0;
   bit m_pend = 1'b0;
   bit m_exp  = 1'b0;

   function automatic logic [W-1:0] to_bcd(input int v);
      logic [W-1:0] r;
      int x;
      r = '0;
      x = v;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   function automatic int from_bcd_clamped(input logic [W-1:0] b);
      int v, scale, d;
      v = 0;
      scale = 1;
      for (int i = 0; i < DIGITS; i++) begin
         d = int'(b[4*i +: 4]);
         if (d > 9) d = 9;
         v += d * scale;
         scale *= 10;
      end
      return v;
   endfunction

   task automatic model_step();
      bit was_end;
      was_end = m_end;
      if (rst) begin
         m_cnt = START; m_end = 1'b0; m_pend = 1'b0;
      end else if (load) begin
         m_cnt = from_bcd_clamped(load_val); m_end = 1'b0; m_pend = 1'b0;
      end else if (BONUS_EN && bonus_valid && !mode && !m_end) begin
         m_cnt = m_cnt + from_bcd_clamped(bonus_val);
         if (m_cnt > MAXV) m_cnt = MAXV;
         if (tick && !pause) m_pend = 1'b1;
      end else if ((tick || m_pend) && !pause) begin
         m_pend = 1'b0;
         if (!m_end) begin
            if (!mode) begin
               if (m_cnt == 0) m_end = 1'b1;
               else m_cnt = m_cnt - 1;
            end else begin
               if (m_cnt == MAXV) m_end = 1'b1;
               else m_cnt = m_cnt + 1;
            end
         end
      end
      m_exp = !rst && m_end && !was_end;
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit t, input bit l, input logic [W-1:0] lv,
                       input bit b, input logic [W-1:0] bv, input bit r);
      tick = t; load = l; load_val = lv; bonus_valid = b; bonus_val = bv; rst = r;
      @(posedge clk);
      model_step();
      #1;
      check_eq("digits", 32'(digits), 32'(to_bcd(m_cnt)));
      check_eq("end_game", 32'(end_game), 32'(m_end));
      check_eq("expire_pulse", 32'(expire_pulse), 32'(m_exp));
      check_eq("warn", 32'(warn), 32'(!mode && !m_end && (m_cnt <= WARN_S)));
      tick = 1'b0; load = 1'b0; bonus_valid = 1'b0; rst = 1'b0;
   endtask

   task automatic idle();
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_tick();
      step(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   task automatic do_load(input logic [W-1:0] v);
      step(1'b0, 1'b1, v, 1'b0, '0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      // Reset
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      step(1'b0, 1'b0, '0, 1'b0, '0, 1'b1);
      check_eq("rst_digits", 32'(digits), 32'h60);
      check_eq("rst_end", 32'(end_game), 32'h0);
      check_eq("rst_warn", 32'(warn), 32'h0);

      // Full countdown to zero, then expiry
      for (int i = 0; i < 60; i++) begin
         do_tick();
         idle();
      end
      check_eq("zero_digits", 32'(digits), 32'h00);
      check_eq("zero_end", 32'(end_game), 32'h0);
      do_tick();
      check_eq("expire_end", 32'(end_game), 32'h1);
      check_eq("expire_pulse", 32'(expire_pulse), 32'h1);
      idle();
      check_eq("expire_once", 32'(expire_pulse), 32'h0);
      do_tick();
      check_eq("after_end_digits", 32'(digits), 32'h00);
      check_eq("after_end_pulse", 32'(expire_pulse), 32'h0);

      // Warning boundary and borrow
      do_load('h10);
      check_eq("warn_at_10", 32'(warn), 32'h1);
      check_eq("load_clears_end", 32'(end_game), 32'h0);
      do_tick();
      check_eq("borrow_10_09", 32'(digits), 32'h09);

`ifdef TIMER_BONUS_EN
      // Bonus with simultaneous tick -> deferred tick
      do_load('h07);
      step(1'b1, 1'b0, '0, 1'b1, 'h15, 1'b0);
      check_eq("bonus_sum", 32'(digits), 32'h22);
      idle();
      check_eq("bonus_deferred", 32'(digits), 32'h21);
      do_load('h70);
      step(1'b0, 1'b0, '0, 1'b1, 'h50, 1'b0);
      check_eq("bonus_saturate", 32'(digits), 32'h99);
`endif

      // Pause discards ticks
      do_load('h30);
      pause = 1'b1;
      for (int i = 0; i < 5; i++) do_tick();
      check_eq("pause_hold", 32'(digits), 32'h30);
      do_load('h4F);
      check_eq("load_clamp", 32'(digits), 32'h49);
      pause = 1'b0;

      // Load while ended
      do_load('h00);
      do_tick();
      check_eq("ended_again", 32'(end_game), 32'h1);
      do_load('h20);
      check_eq("load_clear_end", 32'(end_game), 32'h0);

      // Count up to all nines
      mode = 1'b1;
      do_load('h97);
      do_tick();
      do_tick();
      check_eq("up_99", 32'(digits), 32'h99);
      do_tick();
      check_eq("up_end", 32'(end_game), 32'h1);
      check_eq("up_pulse", 32'(expire_pulse), 32'h1);
      do_load('h40);
`ifdef TIMER_BONUS_EN
      step(1'b0, 1'b0, '0, 1'b1, 'h11, 1'b0);
      check_eq("bonus_up_ignored", 32'(digits), 32'h40);
`endif
      mode = 1'b0;

      // Reset over load, tick and a pending tick
      do_load('h20);
`ifdef TIMER_BONUS_EN
      step(1'b1, 1'b0, '0, 1'b1, 'h05, 1'b0);
`endif
      step(1'b1, 1'b1, 'h33, 1'b0, '0, 1'b1);
      check_eq("rst_over_all", 32'(digits), 32'h60);
      idle();
      check_eq("no_deferred_after_rst", 32'(digits), 32'h60);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] lv, bv;
         bit t, l, b, r;
         if ($urandom_range(0, 49) == 0) mode = ~mode;
         pause = ($urandom_range(0, 5) == 0);
         t  = ($urandom_range(0, 2) == 0);
         l  = ($urandom_range(0, 39) == 0);
         b  = ($urandom_range(0, 14) == 0);
         r  = ($urandom_range(0, 299) == 0);
         lv = W'($urandom);
         bv = W'($urandom_range(0, 'h30));
         step(t, l, lv, b, bv, r);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/bcd_game_timer.md
# bcd_game_timer

Parametrised BCD game timer: successor to the fixed two-digit countdown, running on the system clock with a 1 Hz tick strobe. Counts an N-digit BCD value down (game clock) or up (stopwatch), supports run-time reload, time-bonus add with deferred tick, a low-time warning, and a sticky end-of-game flag. It drives the seven-segment display path and the game-control FSM.

## Interface
- DIGITS, 2, number of BCD digits (1..6); W = 4*DIGITS
- START_VAL, 'h60, BCD value loaded at reset
- WARN_THRESH, 'h10, countdown warning threshold (BCD)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tick  in  1  one-cycle count strobe (1 Hz)
- pause  in  1  1 = ignore ticks
- mode  in  1  0 = count down, 1 = count up
- load  in  1  one-cycle reload request
- load_val  in  W  BCD reload value
- bonus_valid  in  1  one-cycle time-bonus request (TIMER_BONUS_EN only)
- bonus_val  in  W  BCD seconds to add (TIMER_BONUS_EN only)
- digits  out  W  current count, digit 0 = ones, in bits [3:0]
- end_game  out  1  sticky expiry flag
- expire_pulse  out  1  one-cycle pulse when end_game sets
- warn  out  1  countdown value ≤ WARN_THRESH, not ended

## Operation
- Per-cycle priority: rst > load > bonus > tick.
- rst: digits = START_VAL, end_game = 0, expire_pulse = 0, tick_pending = 0.
- load: digits = load_val, end_game = 0, tick_pending = 0; any load_val digit > 9 is clamped to 9.
- tick (pause = 0, end_game = 0):
  - mode 0, count > 0: decrement with BCD borrow (x0 → (x-1)9).
  - mode 0, count = 0: set end_game; count stays 0.
  - mode 1, count < all-9s: increment with BCD carry.
  - mode 1, count = all-9s: set end_game; count holds.
- pause = 1: ticks discarded, not queued. A pending tick is held.
- end_game = 1: ticks and bonus ignored; only load or rst clear it.
- Bonus (mode 0 only; ignored in mode 1): digits = BCD sum, saturating at all-9s. A tick in the same cycle sets tick_pending and is applied on the next cycle with no load, bonus, or pause. A pending tick is dropped by load or rst.
- Mode changes take effect on the next tick; count is untouched.
- warn = (mode == 0) && !end_game && (digits ≤ WARN_THRESH); combinational from registered state.

## Timing
- digits, end_game, and tick_pending are registered. Update is visible the cycle after the qualifying input is sampled.
- expire_pulse is high for exactly the one cycle in which end_game first reads 1.
- Latency tick → digits: 1 cycle. Deferred tick: 2 cycles after the strobe.
- Reset values: digits = START_VAL, end_game = 0, expire_pulse = 0, warn per START_VAL.
- rst asserted mid-count or mid-pending overrides everything in that cycle.

## Configuration
- TIMER_BONUS_EN defined: bonus_valid and bonus_val ports exist; the adder and tick_pending logic are built.
- TIMER_BONUS_EN undefined: both bonus ports are absent. tick_pending is constant 0. Behaviour is otherwise identical.

## Structure
- Shared package `game_timer_pkg`:
  - BCD digit type (4-bit).
  - Constants BCD_NINE and BCD_ZERO.
  - Function `bcd_clamp`.
  - Mode encoding MODE_DOWN = 0, MODE_UP = 1.
- Sub-module `bcd_digit_cell`: one digit with inc/dec/add inputs, carry/borrow in/out, and an is-zero/is-nine flag. The top level instantiates DIGITS copies in a generate chain; the bonus adder reuses the cell's add path.

## Test plan
- Reset with DIGITS = 2, START_VAL = 'h60, mode 0 → digits = 'h60, end_game = 0, warn = 0. 60 ticks → 'h00. Next tick → end_game = 1 and one expire_pulse. A further tick leaves digits at 'h00 with no new pulse.
- Count 'h10 → tick → 'h09; warn already 1 at 'h10 (WARN_THRESH = 'h10).
- Bonus 'h15 with a simultaneous tick at 'h07 → 'h22 next cycle, then 'h21 the following cycle. Bonus 'h50 at 'h70 → saturates at 'h99.
- pause = 1 over 5 ticks at 'h30 → stays 'h30. Load 'h4F → digits = 'h49. Load while end_game = 1 → end_game clears.
- Mode 1 from 'h97 → 3 ticks → 'h99, then end_game = 1 with one pulse. Bonus in mode 1 → ignored.
- rst asserted on the same cycle as load, tick, and a pending tick → digits = START_VAL, with no deferred tick afterwards.
